sram_port_arbiter: RTL and testbench

- Shares the single SRAM controller port between two masters: m0 (data cache) and m1 (instruction fetch / secondary cache).
- Masters hold a level request (wrEn or rdEn) until they see ready.
- The arbiter grants one master at a time and holds the grant across a multi-beat burst, e.g. the cache's two-beat 64-bit line fill.
- It alternates masters round-robin and flags a stalled SRAM with a watchdog.

---
 rtl/sram_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-master arbiter in front of the single SRAM controller port.
// Grants one master at a time, holds the grant across a burst of up to
// MAX_BEATS beats, rotates round-robin (or fixed priority when FAIR=0) and
// raises a sticky watchdog flag when the SRAM stops answering.
module sram_port_arbiter #(
   parameter int FAIR        = 1,
   parameter int MAX_BEATS   = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_address,
   input  logic [31:0] m0_writeData,
   input  logic        m0_wrEn,
   input  logic        m0_rdEn,
   output logic [63:0] m0_readData,
   output logic        m0_ready,
   input  logic [31:0] m1_address,
   input  logic [31:0] m1_writeData,
   input  logic        m1_wrEn,
   input  logic        m1_rdEn,
   output logic [63:0] m1_readData,
   output logic        m1_ready,
   output logic [31:0] sramAddress,
   output logic [31:0] sramWriteData,
   output logic        sramWrEn,
   output logic        sramRdEn,
   input  logic [63:0] sramReadData,
   input  logic        sramReady,
   output logic [1:0]  grant,
   output logic        timeout
);

   localparam int BEAT_W = $clog2(MAX_BEATS + 1);
   localparam int WD_W   = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} stateT;

   stateT             state;
   logic              rrLast;   // last master released: 0 = m0, 1 = m1
   logic [BEAT_W-1:0] beatCnt;
   logic [WD_W-1:0]   wdCnt;

   logic req0;
   logic req1;
   logic curReq;
   logic lastBeat;
   logic releaseGrant;

   // Owner encoding carried in the grant register
   function automatic logic [1:0] grantOf(input stateT s);
      case (s)
         BUSY0:   return 2'b01;
         BUSY1:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   // Winner out of IDLE; a tie goes to the master not served last
   function automatic stateT pickFromIdle(input logic r0, input logic r1, input logic rr);
      if (r0 && r1)
         return (FAIR != 0 && !rr) ? BUSY1 : BUSY0;
      else if (r0)
         return BUSY0;
      else if (r1)
         return BUSY1;
      else
         return IDLE;
   endfunction

   // Next owner when the current one is released: the other waiting master
   // goes first (no bubble) unless fixed priority lets m0 keep the port
   function automatic stateT pickOnRelease(input logic curIsM1, input logic r0, input logic r1);
      if (FAIR == 0 || curIsM1) begin
         if (r0)      return BUSY0;
         else if (r1) return BUSY1;
         else         return IDLE;
      end else begin
         if (r1)      return BUSY1;
         else if (r0) return BUSY0;
         else         return IDLE;
      end
   endfunction

   assign req0 = m0_wrEn | m0_rdEn;
   assign req1 = m1_wrEn | m1_rdEn;

   assign curReq       = (state == BUSY1) ? req1 : req0;
   assign lastBeat     = sramReady && (beatCnt == BEAT_W'(MAX_BEATS - 1));
   assign releaseGrant = (state != IDLE) && (!curReq || lastBeat);

   assign m0_ready = ~req0 | (grant[0] & sramReady);
   assign m1_ready = ~req1 | (grant[1] & sramReady);

   // Arbitration FSM: owner, round-robin pointer, beat count and grant register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         grant   <= 2'b00;
         rrLast  <= 1'b1;
         beatCnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               state   <= pickFromIdle(req0, req1, rrLast);
               grant   <= grantOf(pickFromIdle(req0, req1, rrLast));
               beatCnt <= '0;
            end
            BUSY0, BUSY1: begin
               if (releaseGrant) begin
                  rrLast  <= (state == BUSY1);
                  beatCnt <= '0;
                  state   <= pickOnRelease(state == BUSY1, req0, req1);
                  grant   <= grantOf(pickOnRelease(state == BUSY1, req0, req1));
               end else if (sramReady) begin
                  beatCnt <= beatCnt + BEAT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               grant <= 2'b00;
            end
         endcase
      end
   end

   // Watchdog: count stalled busy cycles, latch timeout once the limit is hit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdCnt   <= '0;
         timeout <= 1'b0;
      end else if (state != IDLE && !sramReady) begin
         if (wdCnt != WD_W'(TIMEOUT_CYC))
            wdCnt <= wdCnt + WD_W'(1);
         if (wdCnt == WD_W'(TIMEOUT_CYC - 1))
            timeout <= 1'b1;
      end else begin
         wdCnt <= '0;
      end
   end

   // SRAM side driven straight from the owner's live request; write beats read
   always_comb begin
      sramAddress   = '0;
      sramWriteData = '0;
      sramWrEn      = 1'b0;
      sramRdEn      = 1'b0;
      m0_readData   = '0;
      m1_readData   = '0;
      case (state)
         BUSY0: begin
            sramAddress   = m0_address;
            sramWriteData = m0_writeData;
            sramWrEn      = m0_wrEn;
            sramRdEn      = m0_rdEn & ~m0_wrEn;
            m0_readData   = sramReadData;
         end
         BUSY1: begin
            sramAddress   = m1_address;
            sramWriteData = m1_writeData;
            sramWrEn      = m1_wrEn;
            sramRdEn      = m1_rdEn & ~m1_wrEn;
            m1_readData   = sramReadData;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a round-robin instance driven from a vector
// table through a scoreboard queue, plus hand-written sequences for fixed
// priority, the watchdog and an asynchronous reset in the middle of a beat.
module tb_sram_port_arbiter;

   localparam logic [31:0] M0_ADDR = 32'h0000_0100;
   localparam logic [31:0] M1_ADDR = 32'h0000_0200;
   localparam logic [31:0] M0_WD   = 32'h0BAD_F00D;
   localparam logic [31:0] M1_WD   = 32'hDEAD_BEEF;
   localparam logic [63:0] RD_DATA = 64'h1122_3344_5566_7788;

   logic        clk;
   logic        rst;
   logic [31:0] m0Address, m0WriteData, m1Address, m1WriteData;
   logic        m0WrEn, m0RdEn, m1WrEn, m1RdEn;
   logic [63:0] sramReadData;
   logic        sramReady;

   logic [63:0] m0ReadData, m1ReadData;
   logic        m0Ready, m1Ready;
   logic [31:0] sramAddress, sramWriteData;
   logic        sramWrEn, sramRdEn;
   logic [1:0]  grant;
   logic        timeout;

   logic [63:0] fpM0ReadData, fpM1ReadData;
   logic        fpM0Ready, fpM1Ready;
   logic [31:0] fpSramAddress, fpSramWriteData;
   logic        fpSramWrEn, fpSramRdEn;
   logic [1:0]  fpGrant;
   logic        fpTimeout;

   int passCnt  = 0;
   int totalCnt = 0;

   sram_port_arbiter #(.FAIR(1), .MAX_BEATS(2), .TIMEOUT_CYC(255)) dut (
      .clk(clk), .rst(rst),
      .m0_address(m0Address), .m0_writeData(m0WriteData), .m0_wrEn(m0WrEn), .m0_rdEn(m0RdEn),
      .m0_readData(m0ReadData), .m0_ready(m0Ready),
      .m1_address(m1Address), .m1_writeData(m1WriteData), .m1_wrEn(m1WrEn), .m1_rdEn(m1RdEn),
      .m1_readData(m1ReadData), .m1_ready(m1Ready),
      .sramAddress(sramAddress), .sramWriteData(sramWriteData),
      .sramWrEn(sramWrEn), .sramRdEn(sramRdEn),
      .sramReadData(sramReadData), .sramReady(sramReady),
      .grant(grant), .timeout(timeout)
   );

   sram_port_arbiter #(.FAIR(0), .MAX_BEATS(2), .TIMEOUT_CYC(255)) dutFp (
      .clk(clk), .rst(rst),
      .m0_address(m0Address), .m0_writeData(m0WriteData), .m0_wrEn(m0WrEn), .m0_rdEn(m0RdEn),
      .m0_readData(fpM0ReadData), .m0_ready(fpM0Ready),
      .m1_address(m1Address), .m1_writeData(m1WriteData), .m1_wrEn(m1WrEn), .m1_rdEn(m1RdEn),
      .m1_readData(fpM1ReadData), .m1_ready(fpM1Ready),
      .sramAddress(fpSramAddress), .sramWriteData(fpSramWriteData),
      .sramWrEn(fpSramWrEn), .sramRdEn(fpSramRdEn),
      .sramReadData(sramReadData), .sramReady(sramReady),
      .grant(fpGrant), .timeout(fpTimeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rstN, m0Wr, m0Rd, m1Wr, m1Rd, rdy;
      logic [1:0] grant;
      logic       m0Rdy, m1Rdy, sWr, sRd;
   } vecT;

   vecT vecs[$];
   vecT sb[$];

   function automatic vecT mk(input logic rstN, input logic m0Wr, input logic m0Rd,
                              input logic m1Wr, input logic m1Rd, input logic rdy,
                              input logic [1:0] g, input logic m0Rdy, input logic m1Rdy,
                              input logic sWr, input logic sRd);
      vecT v;
      v.rstN = rstN; v.m0Wr = m0Wr; v.m0Rd = m0Rd; v.m1Wr = m1Wr; v.m1Rd = m1Rd; v.rdy = rdy;
      v.grant = g; v.m0Rdy = m0Rdy; v.m1Rdy = m1Rdy; v.sWr = sWr; v.sRd = sRd;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Drive one vector at the falling edge, queue its expectation, compare before the rising edge
   task automatic applyVec(input int idx, input vecT v);
      vecT e;
      logic [31:0] eAddr, eWd;
      @(negedge clk);
      rst = v.rstN; m0WrEn = v.m0Wr; m0RdEn = v.m0Rd; m1WrEn = v.m1Wr; m1RdEn = v.m1Rd;
      sramReady = v.rdy;
      sb.push_back(v);
      #2;
      e = sb.pop_front();
      eAddr = (e.grant == 2'b01) ? M0_ADDR : (e.grant == 2'b10) ? M1_ADDR : 32'h0;
      eWd   = (e.grant == 2'b01) ? M0_WD   : (e.grant == 2'b10) ? M1_WD   : 32'h0;
      check($sformatf("row%0d grant", idx), {62'h0, grant}, {62'h0, e.grant});
      check($sformatf("row%0d m0_ready", idx), {63'h0, m0Ready}, {63'h0, e.m0Rdy});
      check($sformatf("row%0d m1_ready", idx), {63'h0, m1Ready}, {63'h0, e.m1Rdy});
      check($sformatf("row%0d sramWrEn", idx), {63'h0, sramWrEn}, {63'h0, e.sWr});
      check($sformatf("row%0d sramRdEn", idx), {63'h0, sramRdEn}, {63'h0, e.sRd});
      check($sformatf("row%0d sramAddress", idx), {32'h0, sramAddress}, {32'h0, eAddr});
      check($sformatf("row%0d sramWriteData", idx), {32'h0, sramWriteData}, {32'h0, eWd});
      check($sformatf("row%0d m0_readData", idx), m0ReadData, (e.grant == 2'b01) ? RD_DATA : 64'h0);
      check($sformatf("row%0d m1_readData", idx), m1ReadData, (e.grant == 2'b10) ? RD_DATA : 64'h0);
   endtask

   task automatic drive(input logic rstN, input logic m0Rd, input logic m1Rd, input logic rdy);
      rst = rstN; m0WrEn = 1'b0; m0RdEn = m0Rd; m1WrEn = 1'b0; m1RdEn = m1Rd; sramReady = rdy;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: got no finish, expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      m0Address = M0_ADDR; m1Address = M1_ADDR;
      m0WriteData = M0_WD; m1WriteData = M1_WD;
      sramReadData = RD_DATA;
      drive(1'b0, 1'b0, 1'b0, 1'b0);

      // rstN m0Wr m0Rd m1Wr m1Rd rdy | grant m0Rdy m1Rdy sWr sRd
      // m0 reads 0x100 alone
      vecs.push_back(mk(0,0,0,0,0,0, 2'b00,1,1,0,0));
      vecs.push_back(mk(1,0,1,0,0,0, 2'b00,0,1,0,0));
      vecs.push_back(mk(1,0,1,0,0,0, 2'b01,0,1,0,1));
      vecs.push_back(mk(1,0,1,0,0,1, 2'b01,1,1,0,1));
      vecs.push_back(mk(1,0,0,0,0,0, 2'b01,1,1,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 2'b00,1,1,0,0));
      // both read together after reset: m0 two beats, m1 two beats, m0 again
      vecs.push_back(mk(0,0,1,0,1,0, 2'b00,0,0,0,0));
      vecs.push_back(mk(1,0,1,0,1,0, 2'b00,0,0,0,0));
      vecs.push_back(mk(1,0,1,0,1,1, 2'b01,1,0,0,1));
      vecs.push_back(mk(1,0,1,0,1,1, 2'b01,1,0,0,1));
      vecs.push_back(mk(1,0,1,0,1,0, 2'b10,0,0,0,1));
      vecs.push_back(mk(1,0,1,0,1,1, 2'b10,0,1,0,1));
      vecs.push_back(mk(1,0,1,0,1,1, 2'b10,0,1,0,1));
      vecs.push_back(mk(1,0,1,0,1,0, 2'b01,0,0,0,1));
      // m1 with wrEn and rdEn both set: write wins, one beat, then drops
      vecs.push_back(mk(0,0,0,0,0,0, 2'b00,1,1,0,0));
      vecs.push_back(mk(1,0,0,1,1,0, 2'b00,1,0,0,0));
      vecs.push_back(mk(1,0,0,1,1,0, 2'b10,1,0,1,0));
      vecs.push_back(mk(1,0,0,1,1,1, 2'b10,1,1,1,0));
      vecs.push_back(mk(1,0,0,0,0,0, 2'b10,1,1,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 2'b00,1,1,0,0));

      for (int i = 0; i < vecs.size(); i++) applyVec(i, vecs[i]);

      // Fixed priority: m0 keeps the port across releases, m1 never served
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1);
      #2;
      check("fp idle grant", {62'h0, fpGrant}, 64'h0);
      check("fp idle m1_ready", {63'h0, fpM1Ready}, 64'h0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk); #2;
         check($sformatf("fp c%0d grant", c), {62'h0, fpGrant}, 64'h1);
         check($sformatf("fp c%0d m1_ready", c), {63'h0, fpM1Ready}, 64'h0);
         check($sformatf("fp c%0d m0_ready", c), {63'h0, fpM0Ready}, 64'h1);
         check($sformatf("fp c%0d sramRdEn", c), {63'h0, fpSramRdEn}, 64'h1);
         check($sformatf("fp c%0d sramWrEn", c), {63'h0, fpSramWrEn}, 64'h0);
         check($sformatf("fp c%0d sramAddress", c), {32'h0, fpSramAddress}, {32'h0, M0_ADDR});
         check($sformatf("fp c%0d sramWriteData", c), {32'h0, fpSramWriteData}, {32'h0, M0_WD});
         check($sformatf("fp c%0d m0_readData", c), fpM0ReadData, RD_DATA);
         check($sformatf("fp c%0d m1_readData", c), fpM1ReadData, 64'h0);
         check($sformatf("fp c%0d timeout", c), {63'h0, fpTimeout}, 64'h0);
      end

      // Watchdog: m0 granted, SRAM silent for 255 cycles
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk); #2;
      check("wd granted", {62'h0, grant}, 64'h1);
      check("wd start timeout", {63'h0, timeout}, 64'h0);
      repeat (254) @(negedge clk);
      #2;
      check("wd 254 timeout", {63'h0, timeout}, 64'h0);
      @(negedge clk); #2;
      check("wd 255 timeout", {63'h0, timeout}, 64'h1);
      check("wd grant kept", {62'h0, grant}, 64'h1);
      sramReady = 1'b1;
      repeat (4) @(negedge clk);
      #2;
      check("wd sticky timeout", {63'h0, timeout}, 64'h1);

      // Asynchronous reset in the middle of an m0 beat
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("ar busy grant", {62'h0, grant}, 64'h1);
      check("ar busy sramRdEn", {63'h0, sramRdEn}, 64'h1);
      #2;
      rst = 1'b0;
      #1;
      check("ar sramRdEn", {63'h0, sramRdEn}, 64'h0);
      check("ar sramWrEn", {63'h0, sramWrEn}, 64'h0);
      check("ar grant", {62'h0, grant}, 64'h0);
      check("ar timeout", {63'h0, timeout}, 64'h0);
      m1RdEn = 1'b1;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("ar first grant", {62'h0, grant}, 64'h1);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
